// File: rtl/nested_loop_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc_pkg : shared types and defaults for nested_loop_counter           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lc_pkg;

  localparam int LC_NUM_LVL   = 3;
  localparam int LC_CNT_WIDTH = 8;

  localparam logic LC_DIR_UP   = 1'b0;
  localparam logic LC_DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lc_state_e;

endpackage
`default_nettype wire

// File: rtl/nested_loop_counter_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loop_cnt_stage : one level of the nested loop counter                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module loop_cnt_stage
  import lc_pkg::*;
#(
  parameter int CNT_WIDTH = LC_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic                 i_carry,
  input  logic                 i_dir,
  input  logic [CNT_WIDTH-1:0] i_bound,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_terminal,
  output logic                 o_carry,
  output logic                 o_wrap
);

  localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_bound;
  logic                 r_dir;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_wrap;
  logic [CNT_WIDTH-1:0] w_start;
  logic [CNT_WIDTH-1:0] w_step;
  logic                 w_terminal;

  assign w_start    = (r_dir == LC_DIR_UP) ? '0 : r_bound;
  assign w_terminal = (r_dir == LC_DIR_DOWN) ? (r_cnt == '0) : (r_cnt == r_bound);
  assign w_step     = (r_dir == LC_DIR_DOWN) ? (r_cnt - c_one) : (r_cnt + c_one);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bound <= '0;
      r_dir   <= LC_DIR_UP;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (i_load) begin
      r_bound <= i_bound;
      r_dir   <= i_dir;
      r_cnt   <= (i_dir == LC_DIR_DOWN) ? i_bound : '0;
      r_wrap  <= 1'b0;
    end else begin
      // A terminal level never steps past its bound; it reloads instead.
      r_wrap <= i_carry & w_terminal;
      if (i_carry) begin
        r_cnt <= w_terminal ? w_start : w_step;
      end
    end
  end

  assign o_cnt      = r_cnt;
  assign o_terminal = w_terminal;
  assign o_carry    = i_carry & w_terminal;
  assign o_wrap     = r_wrap;

endmodule
`default_nettype wire

// File: rtl/nested_loop_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nested_loop_counter : chained loop counters with wrap/done reporting |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nested_loop_counter
  import lc_pkg::*;
#(
  parameter int NUM_LVL   = LC_NUM_LVL,
  parameter int CNT_WIDTH = LC_CNT_WIDTH
) (
  input  logic                         lc_clk,
  input  logic                         lc_rst,
  input  logic                         lc_start,
  input  logic                         lc_abort,
  input  logic                         lc_en,
  input  logic                         lc_dir,
  input  logic [NUM_LVL*CNT_WIDTH-1:0] lc_upto,
  output logic [NUM_LVL*CNT_WIDTH-1:0] lc_cnt_out,
  output logic [NUM_LVL-1:0]           lc_last,
  output logic [NUM_LVL-1:0]           lc_wrap,
  output logic                         lc_busy,
  output logic                         lc_done
);

  lc_state_e r_state;
  logic      r_done;

  logic w_run;
  logic w_accept;
  logic w_abort;
  logic w_clear;
  logic w_adv;
  logic w_final;

  logic [NUM_LVL-1:0] w_carry_in;
  logic [NUM_LVL-1:0] w_carry_out;
  logic [NUM_LVL-1:0] w_term;
  logic [NUM_LVL-1:0] w_last;
  logic [NUM_LVL-1:0] w_wrap;

  assign w_run    = (r_state == RUN);
  assign w_accept = (r_state == IDLE) & lc_start & ~lc_abort;
  assign w_abort  = lc_abort & (r_state != IDLE);
  // Counters are zeroed on abort and on the way out of DONE so IDLE reads 0.
  assign w_clear  = w_abort | (r_state == DONE);
  assign w_adv    = w_run & lc_en & ~lc_abort;
  assign w_final  = w_carry_out[NUM_LVL-1];

  for (genvar i = 0; i < NUM_LVL; i++) begin : g_lvl
    if (i == 0) begin : g_first
      assign w_carry_in[i] = w_adv;
      assign w_last[i]     = w_term[i];
    end else begin : g_chain
      assign w_carry_in[i] = w_carry_out[i-1];
      assign w_last[i]     = w_last[i-1] & w_term[i];
    end

    loop_cnt_stage #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_stage (
      .clk        (lc_clk),
      .rst        (lc_rst),
      .i_load     (w_accept),
      .i_clear    (w_clear),
      .i_carry    (w_carry_in[i]),
      .i_dir      (lc_dir),
      .i_bound    (lc_upto[i*CNT_WIDTH +: CNT_WIDTH]),
      .o_cnt      (lc_cnt_out[i*CNT_WIDTH +: CNT_WIDTH]),
      .o_terminal (w_term[i]),
      .o_carry    (w_carry_out[i]),
      .o_wrap     (w_wrap[i])
    );
  end

  always_ff @(posedge lc_clk) begin
    if (lc_rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_final;
      case (r_state)
        IDLE:    if (w_accept) r_state <= RUN;
        RUN: begin
          if (lc_abort)     r_state <= IDLE;
          else if (w_final) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lc_last = w_run ? w_last : '0;
  assign lc_wrap = w_wrap;
  assign lc_busy = w_run;
  assign lc_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nested_loop_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nested_loop_counter : scoreboard bench for nested_loop_counter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_nested_loop_counter;

  typedef struct packed {
    logic [11:0] cnt;
    logic [2:0]  wrap;
    logic [2:0]  last;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        en;
  logic        dir;
  logic [11:0] upto;
  logic [11:0] cnt_out;
  logic [2:0]  last;
  logic [2:0]  wrap;
  logic        busy;
  logic        done;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  logic [11:0] seq [0:23];
  bit   cur_dir;

  nested_loop_counter #(
    .NUM_LVL   (3),
    .CNT_WIDTH (4)
  ) dut (
    .lc_clk     (clk),
    .lc_rst     (rst),
    .lc_start   (start),
    .lc_abort   (abort),
    .lc_en      (en),
    .lc_dir     (dir),
    .lc_upto    (upto),
    .lc_cnt_out (cnt_out),
    .lc_last    (last),
    .lc_wrap    (wrap),
    .lc_busy    (busy),
    .lc_done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: any visible activity must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && (busy || done || wrap != 3'b000 || cnt_out != 12'h000)) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: cnt=%h wrap=%b last=%b busy=%b done=%b, required no activity",
                 cnt_out, wrap, last, busy, done);
      end else begin
        e = q.pop_front();
        if (cnt_out !== e.cnt || wrap !== e.wrap || last !== e.last ||
            busy !== e.busy || done !== e.done) begin
          errors++;
          $display("FAIL scoreboard: got cnt=%h wrap=%b last=%b busy=%b done=%b, required cnt=%h wrap=%b last=%b busy=%b done=%b",
                   cnt_out, wrap, last, busy, done, e.cnt, e.wrap, e.last, e.busy, e.done);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (cnt_out !== 12'h000 || wrap !== 3'b000 || last !== 3'b000 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got cnt=%h wrap=%b last=%b busy=%b done=%b, required all zero",
               name, cnt_out, wrap, last, busy, done);
    end
  endtask

  // Index sequence for upto={3,2,1}: level2 outermost, level0 innermost.
  task automatic build_seq(input bit d);
    int idx = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 2; c++) begin
          seq[idx] = {4'(d ? 3 - a : a), 4'(d ? 2 - b : b), 4'(d ? 1 - c : c)};
          idx++;
        end
    cur_dir = d;
  endtask

  function automatic exp_t mk_exp(input int k, input bit adv);
    exp_t        e;
    logic [11:0] st;
    logic [11:0] tv;
    logic [11:0] cur;
    logic [11:0] prv;
    st = cur_dir ? 12'h321 : 12'h000;
    tv = cur_dir ? 12'h000 : 12'h321;
    e  = '0;
    if (k == 24) begin
      e.cnt  = st;
      e.wrap = 3'b111;
      e.done = 1'b1;
    end else begin
      cur    = seq[k];
      prv    = (k > 0) ? seq[k-1] : st;
      e.cnt  = cur;
      e.busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e.wrap[i] = adv && (cur[i*4 +: 4] == st[i*4 +: 4]) && (prv[i*4 +: 4] != st[i*4 +: 4]);
      end
      e.last[0] = (cur[3:0] == tv[3:0]);
      e.last[1] = e.last[0] && (cur[7:4] == tv[7:4]);
      e.last[2] = e.last[1] && (cur[11:8] == tv[11:8]);
    end
    return e;
  endfunction

  // Start a run with upto={3,2,1}, then advance until stop_at iterations;
  // two stall cycles are inserted once stall_at advances have been made.
  task automatic run_to(input bit d, input int stall_at, input int stop_at);
    int k = 0;
    bit stalled = 1'b0;
    build_seq(d);
    upto  = 12'h321;
    dir   = d;
    start = 1'b1;
    en    = 1'b0;
    q.push_back(mk_exp(0, 1'b0));
    step();
    start = 1'b0;
    upto  = 12'hfff;
    dir   = ~d;
    while (k < stop_at) begin
      if (k == stall_at && !stalled) begin
        en = 1'b0;
        repeat (2) begin
          q.push_back(mk_exp(k, 1'b0));
          step();
        end
        stalled = 1'b1;
      end
      en = 1'b1;
      k++;
      q.push_back(mk_exp(k, 1'b1));
      step();
    end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; en = 1'b0; dir = 1'b0; upto = 12'h000;
    repeat (3) step();
    check_idle("reset_state");
    rst    = 1'b0;
    mon_en = 1'b1;
    step();
    check_idle("idle_after_reset");

    // Full up-count run, then DONE -> IDLE.
    run_to(1'b0, -1, 24);
    step();
    check_idle("idle_after_up_run");

    // Full down-count run with a mid-run stall.
    run_to(1'b1, 5, 24);
    step();
    check_idle("idle_after_down_run");

    // Up-count run with stall 1,0,0,1 around a level-0 wrap.
    run_to(1'b0, 10, 24);
    step();
    check_idle("idle_after_stall_run");

    // All bounds zero: terminal immediately, done after one advance.
    upto = 12'h000; dir = 1'b0; start = 1'b1;
    q.push_back('{cnt: 12'h000, wrap: 3'b000, last: 3'b111, busy: 1'b1, done: 1'b0});
    step();
    start = 1'b0; en = 1'b1;
    q.push_back('{cnt: 12'h000, wrap: 3'b111, last: 3'b000, busy: 1'b0, done: 1'b1});
    step();
    en = 1'b0;
    step();
    check_idle("idle_after_zero_bounds");

    // Abort at index (1,1,0) together with an advance.
    run_to(1'b0, -1, 8);
    abort = 1'b1; en = 1'b1;
    step();
    abort = 1'b0; en = 1'b0;
    check_idle("abort_clears");
    step();
    check_idle("abort_no_done");

    // Start while busy is ignored, then a mid-run reset.
    run_to(1'b0, -1, 3);
    start = 1'b1; upto = 12'h000; dir = 1'b1; en = 1'b1;
    q.push_back(mk_exp(4, 1'b1));
    step();
    start = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    check_idle("reset_mid_run");

    // Restart after reset begins from index 0 and completes normally.
    run_to(1'b0, -1, 24);
    step();
    check_idle("idle_after_restart");
    repeat (3) step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: %0d entries left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
